// File: rtl/unit_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : unit_test_sequencer
// Brief    : Ordered regression controller that launches masked unit-test
//            channels one at a time and records pass / fail / timeout.
// Revision : 1.0 - initial release
// ============================================================================
module unit_test_sequencer #(
    parameter int NUM_CH  = 15,
    parameter int TIMEOUT = 1024,
    parameter int WIDTH   = 32,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W   = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_pass,
    output logic [NUM_CH-1:0] ch_start,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CH_W-1:0]   cur_ch,
    output logic [NUM_CH-1:0] pass_vec,
    output logic [NUM_CH-1:0] fail_vec,
    output logic [NUM_CH-1:0] timeout_vec,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic [WIDTH-1:0]  run_cycles
);

    localparam int                c_TMR_W    = $clog2(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   c_LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] c_ONE_HOT  = NUM_CH'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SELECT = 3'd1;
    localparam logic [2:0] c_LAUNCH = 3'd2;
    localparam logic [2:0] c_WAIT   = 3'd3;
    localparam logic [2:0] c_RECORD = 3'd4;
    localparam logic [2:0] c_FINISH = 3'd5;

    logic [2:0]         r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_got_pass;
    logic               r_got_timeout;

    logic w_sel_en;
    logic w_cur_done;
    logic w_cur_pass;
    logic w_is_last;

    assign w_sel_en   = r_mask[cur_ch];
    assign w_cur_done = ch_done[cur_ch];
    assign w_cur_pass = ch_pass[cur_ch];
    assign w_is_last  = (cur_ch == c_LAST_CH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_mask        <= '0;
            r_timer       <= '0;
            r_got_pass    <= 1'b0;
            r_got_timeout <= 1'b0;
            ch_start      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            cur_ch        <= '0;
            pass_vec      <= '0;
            fail_vec      <= '0;
            timeout_vec   <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            run_cycles    <= '0;
        end else begin
            ch_start <= '0;
            done     <= 1'b0;
            if (busy && (run_cycles != '1)) begin
                run_cycles <= run_cycles + WIDTH'(1);
            end

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mask      <= ch_mask;
                        pass_vec    <= '0;
                        fail_vec    <= '0;
                        timeout_vec <= '0;
                        pass_count  <= '0;
                        fail_count  <= '0;
                        run_cycles  <= '0;
                        aborted     <= 1'b0;
                        cur_ch      <= '0;
                        busy        <= 1'b1;
                        r_state     <= c_SELECT;
                    end
                end
                c_FINISH: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    // Abort overrides any verdict arriving in the same cycle.
                    if (abort) begin
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        r_state <= c_FINISH;
                    end else begin
                        case (r_state)
                            c_SELECT: begin
                                if (w_sel_en) begin
                                    ch_start <= c_ONE_HOT << cur_ch;
                                    r_state  <= c_LAUNCH;
                                end else if (w_is_last) begin
                                    done    <= 1'b1;
                                    r_state <= c_FINISH;
                                end else begin
                                    cur_ch <= cur_ch + CH_W'(1);
                                end
                            end
                            c_LAUNCH: begin
                                r_timer <= '0;
                                r_state <= c_WAIT;
                            end
                            c_WAIT: begin
                                if (w_cur_done) begin
                                    r_got_pass    <= w_cur_pass;
                                    r_got_timeout <= 1'b0;
                                    r_state       <= c_RECORD;
                                end else if (r_timer == c_TMR_LAST) begin
                                    r_got_pass    <= 1'b0;
                                    r_got_timeout <= 1'b1;
                                    r_state       <= c_RECORD;
                                end else begin
                                    r_timer <= r_timer + c_TMR_W'(1);
                                end
                            end
                            c_RECORD: begin
                                if (r_got_pass) begin
                                    pass_vec[cur_ch] <= 1'b1;
                                    pass_count       <= pass_count + CNT_W'(1);
                                end else begin
                                    fail_vec[cur_ch] <= 1'b1;
                                    fail_count       <= fail_count + CNT_W'(1);
                                    if (r_got_timeout) begin
                                        timeout_vec[cur_ch] <= 1'b1;
                                    end
                                end
                                if (w_is_last) begin
                                    done    <= 1'b1;
                                    r_state <= c_FINISH;
                                end else begin
                                    cur_ch  <= cur_ch + CH_W'(1);
                                    r_state <= c_SELECT;
                                end
                            end
                            default: begin
                                busy    <= 1'b0;
                                r_state <= c_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/unit_test_sequencer.md
Name: unit_test_sequencer

Overview:
- Synthesizable sequencer that runs up to NUM_CH unit-test channels (adder, alu, condcheck, mux, imem, dmem, extend, regfile, flops, hazard unit, ...) one at a time.
- Each channel is enabled by a mask bit. The block launches it with a start pulse, waits for done with a timeout, and records pass, fail or timeout.
- It replaces free-running parallel benches with a deterministic, ordered, self-checking regression controller sitting above the per-unit benches.

Parameters:
- NUM_CH, 15, number of test channels (1..32).
- TIMEOUT, 1024, max WAIT cycles per channel before a timeout is declared (>=2).
- WIDTH, 32, width of run_cycles counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
- start  input  1  begin a regression run; sampled only in IDLE.
- abort  input  1  terminate the current run early.
- ch_mask  input  NUM_CH  per-channel enable; latched on accepted start.
- ch_done  input  NUM_CH  per-channel completion; only bit cur_ch is sampled, only in WAIT.
- ch_pass  input  NUM_CH  per-channel verdict; sampled together with ch_done.
- ch_start  output  NUM_CH  one-hot, single-cycle launch pulse.
- busy  output  1  high from the cycle after start is accepted until FINISH completes.
- done  output  1  single-cycle pulse in FINISH.
- aborted  output  1  set if the last run ended via abort; held until next start.
- cur_ch  output  $clog2(NUM_CH)  index of the channel being processed.
- pass_vec, fail_vec, timeout_vec  output  NUM_CH each  per-channel results.
- pass_count, fail_count  output  $clog2(NUM_CH+1) each  totals; timeouts count as fails.
- run_cycles  output  WIDTH  cycles spent busy; saturates at all-ones.

Behaviour:
- Reset (reset=0 at edge): state IDLE. All outputs 0, including ch_start, busy, done, aborted, vectors, counts, run_cycles and cur_ch. Reset mid-run drops ch_start and busy at that edge; results are lost.
- FSM states: IDLE, SELECT, LAUNCH, WAIT, RECORD, FINISH.
- IDLE:
  - start=1: latch ch_mask; clear vectors, counts, run_cycles, aborted; cur_ch=0; go to SELECT.
  - Results from the previous run are held in IDLE.
- SELECT:
  - mask[cur_ch]=0: if cur_ch==NUM_CH-1, go to FINISH; else cur_ch+1 and stay in SELECT (one cycle per skipped channel).
  - mask[cur_ch]=1: go to LAUNCH.
- LAUNCH: ch_start[cur_ch]=1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - ch_done[cur_ch]=1: capture ch_pass[cur_ch]; go to RECORD.
  - Otherwise, at timer==TIMEOUT-1 (i.e. TIMEOUT WAIT cycles without done): mark timeout; go to RECORD.
  - done and timeout in the same cycle: done wins.
  - ch_done on any other bit is ignored.
- RECORD:
  - Set exactly one of pass_vec, fail_vec or timeout_vec+fail_vec bit cur_ch; increment the matching count.
  - If cur_ch==NUM_CH-1, go to FINISH; else cur_ch+1, go to SELECT.
- FINISH: done=1 for one cycle; busy deasserts next cycle; go to IDLE.
- Minimum latency per enabled channel: 4 cycles (SELECT, LAUNCH, WAIT with done already high, RECORD).
- abort=1 in any non-IDLE state except FINISH:
  - go to FINISH next cycle and set aborted.
  - Channels not yet recorded keep their result bits 0.
  - An abort in LAUNCH does not suppress that cycle's ch_start.
- start while busy is ignored. start and abort together in IDLE: start accepted, abort ignored.
- All-zero mask: NUM_CH SELECT cycles, then FINISH; counts are 0.
- run_cycles increments every cycle while busy=1.
- Invariant: pass_count+fail_count equals popcount of the recorded channels.

Test Plan:
- NUM_CH=4, mask=4'b1111, each ch_done/ch_pass=1 one cycle after its ch_start -> ch_start pulses ch0..ch3 in order, 4 cycles apart; pass_vec=4'b1111, pass_count=4; done pulses once, 16 cycles after start is accepted.
- mask=4'b0101, ch0 passes, ch2 returns ch_pass=0 -> ch_start never asserts for ch1/ch3; pass_vec=4'b0001, fail_vec=4'b0100, fail_count=1.
- TIMEOUT=8, mask=4'b0010, ch1 never done -> WAIT lasts exactly 8 cycles; timeout_vec=4'b0010, fail_vec=4'b0010, fail_count=1.
- mask=0 -> done pulses after NUM_CH SELECT cycles; all counts 0; no ch_start activity.
- Run mask=4'b1111, assert abort while waiting on ch1 -> done next cycle+1; aborted=1; only bit0 recorded; a new start clears aborted and the vectors.
- reset=0 while in WAIT on ch2 -> next edge: all outputs 0, state IDLE; a new start runs cleanly from ch0; ch_done/ch_pass pulses on a non-current channel during WAIT are ignored.
